sobel_stream_gradient: RTL and testbench

Streaming, parametrised successor to the combinational 3x3 Sobel gradient stage. It accepts one raster-order pixel per handshake and buffers two image lines internally, so it builds its own 3x3 window. It computes signed Gx/Gy and a saturated magnitude through a stall-able pipeline, with valid/ready on both sides. It sits between the frame reader and the edge-map writer.

---
 rtl/sobel_stream_gradient.sv | 161 ++++++++++++++++
 tb/tb_sobel_stream_gradient.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream_gradient.sv
// sobel_stream_gradient: streaming 3x3 Sobel gradient with internal line buffers.
// Accepts one raster-order pixel per valid/ready handshake, keeps rows r-1 and
// r-2 in two line buffers, forms a 3x3 window and produces signed Gx/Gy plus a
// saturated |Gx|+|Gy| magnitude through a three-stage stall-able pipeline.
// Optional feature macro: SOBEL_THRESH_EN (adds thresh input and edge_o output).
//
// Ports:
//   clk       in   clock, all state on rising edge
//   reset     in   asynchronous active-high reset
//   in_valid  in   in_pixel valid
//   in_ready  out  block can accept in_pixel this cycle (= !stall)
//   in_pixel  in   raster-order pixel, PIX_W bits
//   out_valid out  gx/gy/mag/out_last valid
//   out_ready in   downstream accepts output this cycle
//   gx, gy    out  signed gradients, PIX_W+3 bits
//   mag       out  min(|gx|+|gy|, 2^OUT_W-1)
//   out_last  out  final output of a frame
//   thresh    in   (SOBEL_THRESH_EN) edge threshold, OUT_W bits
//   edge_o    out  (SOBEL_THRESH_EN) mag >= thresh, aligned with mag
module sobel_stream_gradient #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned OUT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PIX_W-1:0]        in_pixel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [PIX_W+2:0] gx,
  output logic signed [PIX_W+2:0] gy,
  output logic [OUT_W-1:0]        mag,
  output logic                    out_last
`ifdef SOBEL_THRESH_EN
  ,
  input  logic [OUT_W-1:0]        thresh,
  output logic                    edge_o
`endif
);

  localparam int unsigned G_W   = PIX_W + 3;
  localparam int unsigned MAG_W = PIX_W + 4;
  localparam int unsigned SAT_W = (MAG_W > OUT_W) ? MAG_W : OUT_W;
  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  logic stall;
  logic accept;

  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;

  // Line buffers: lb1 holds row r-1, lb2 holds row r-2 (not reset).
  logic [PIX_W-1:0] lb1_q [IMG_W];
  logic [PIX_W-1:0] lb2_q [IMG_W];
  logic [PIX_W-1:0] lb1_rd;
  logic [PIX_W-1:0] lb2_rd;

  // 3x3 window, P1=(r-2,c-2) .. P9=(r,c)
  logic [PIX_W-1:0] p1_q, p2_q, p3_q, p4_q, p5_q, p6_q, p7_q, p8_q, p9_q;

  logic v0_q, last0_q;
  logic v1_q, last1_q;
  logic signed [G_W-1:0] gx_s1_q, gy_s1_q;

  logic [G_W-1:0]        gx_pos, gx_neg, gy_pos, gy_neg;
  logic signed [G_W-1:0] gx_d, gy_d;
  logic [G_W-1:0]        abs_x, abs_y;
  logic [SAT_W-1:0]      sum_ext;
  logic [SAT_W-1:0]      sat_max;
  logic [OUT_W-1:0]      mag_d;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;
  assign lb1_rd   = lb1_q[col_q];
  assign lb2_rd   = lb2_q[col_q];

  // Sobel kernels on the captured window.
  always_comb begin
    gx_pos = G_W'(p3_q) + (G_W'(p6_q) << 1) + G_W'(p9_q);
    gx_neg = G_W'(p1_q) + (G_W'(p4_q) << 1) + G_W'(p7_q);
    gy_pos = G_W'(p7_q) + (G_W'(p8_q) << 1) + G_W'(p9_q);
    gy_neg = G_W'(p1_q) + (G_W'(p2_q) << 1) + G_W'(p3_q);
    gx_d   = $signed(gx_pos - gx_neg);
    gy_d   = $signed(gy_pos - gy_neg);
  end

  // |gx|+|gy| with saturation to OUT_W bits; |grad| <= 4*(2^PIX_W-1) so negation is safe.
  always_comb begin
    abs_x   = gx_s1_q[G_W-1] ? G_W'(-gx_s1_q) : G_W'(gx_s1_q);
    abs_y   = gy_s1_q[G_W-1] ? G_W'(-gy_s1_q) : G_W'(gy_s1_q);
    sum_ext = SAT_W'(abs_x) + SAT_W'(abs_y);
    sat_max = SAT_W'({OUT_W{1'b1}});
    mag_d   = (sum_ext > sat_max) ? {OUT_W{1'b1}} : OUT_W'(sum_ext);
  end

  // Line buffer write: current row slides into r-1, old r-1 slides into r-2.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[col_q] <= in_pixel;
      lb2_q[col_q] <= lb1_rd;
    end
  end

  // Counters, window and pipeline; everything freezes while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q     <= '0;
      row_q     <= '0;
      p1_q      <= '0; p2_q <= '0; p3_q <= '0;
      p4_q      <= '0; p5_q <= '0; p6_q <= '0;
      p7_q      <= '0; p8_q <= '0; p9_q <= '0;
      v0_q      <= 1'b0;
      last0_q   <= 1'b0;
      v1_q      <= 1'b0;
      last1_q   <= 1'b0;
      gx_s1_q   <= '0;
      gy_s1_q   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      gx        <= '0;
      gy        <= '0;
      mag       <= '0;
`ifdef SOBEL_THRESH_EN
      edge_o    <= 1'b0;
`endif
    end else if (!stall) begin
      if (accept) begin
        if (col_q == COL_W'(IMG_W - 1)) begin
          col_q <= '0;
          row_q <= (row_q == ROW_W'(IMG_H - 1)) ? '0 : row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
        p1_q <= p2_q; p2_q <= p3_q; p3_q <= lb2_rd;
        p4_q <= p5_q; p5_q <= p6_q; p6_q <= lb1_rd;
        p7_q <= p8_q; p8_q <= p9_q; p9_q <= in_pixel;
      end
      // Border suppression: only full windows (row>=2, col>=2) are emitted.
      v0_q      <= accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
      last0_q   <= accept && (row_q == ROW_W'(IMG_H - 1)) && (col_q == COL_W'(IMG_W - 1));
      v1_q      <= v0_q;
      last1_q   <= last0_q;
      gx_s1_q   <= gx_d;
      gy_s1_q   <= gy_d;
      out_valid <= v1_q;
      out_last  <= last1_q;
      gx        <= gx_s1_q;
      gy        <= gy_s1_q;
      mag       <= mag_d;
`ifdef SOBEL_THRESH_EN
      edge_o    <= (mag_d >= thresh);
`endif
    end
  end

endmodule

// File: tb/tb_sobel_stream_gradient.sv
// Self-checking bench for sobel_stream_gradient on an 8x6 image.
module tb_sobel_stream_gradient;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned IMG_W = 8;
  localparam int unsigned IMG_H = 6;
  localparam int unsigned OUT_W = 8;
  localparam int NOUT = (IMG_W - 2) * (IMG_H - 2);

  typedef struct {
    int     gx;
    int     gy;
    int     mag;
    bit     last;
    bit     edge_b;
    longint cyc;
  } res_t;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    in_valid;
  logic                    in_ready;
  logic [PIX_W-1:0]        in_pixel;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [PIX_W+2:0] gx;
  logic signed [PIX_W+2:0] gy;
  logic [OUT_W-1:0]        mag;
  logic                    out_last;
  logic [OUT_W-1:0]        thresh;
  logic                    edge_w;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  longint      cyc     = 0;
  longint      first_acc, last_acc, acc22;
  int          img [IMG_H][IMG_W];
  res_t        exp_q[$];
  res_t        obs_q[$];

  sobel_stream_gradient #(
    .PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .OUT_W(OUT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pixel (in_pixel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .gx       (gx),
    .gy       (gy),
    .mag      (mag),
    .out_last (out_last)
`ifdef SOBEL_THRESH_EN
    ,
    .thresh   (thresh),
    .edge_o   (edge_w)
`endif
  );

`ifndef SOBEL_THRESH_EN
  assign edge_w = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every transferred output.
  always @(negedge clk) begin
    res_t o;
    if (!reset && out_valid && out_ready) begin
      o.gx = int'(gx); o.gy = int'(gy); o.mag = int'(mag);
      o.last = out_last; o.edge_b = edge_w; o.cyc = cyc;
      obs_q.push_back(o);
    end
  end

  function automatic res_t model(input int r, input int c);
    res_t e;
    int ax, ay;
    e.gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
         - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
    e.gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
         - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
    ax = (e.gx < 0) ? -e.gx : e.gx;
    ay = (e.gy < 0) ? -e.gy : e.gy;
    e.mag = (ax + ay > 255) ? 255 : ax + ay;
    e.last = (r == IMG_H - 1) && (c == IMG_W - 1);
    e.edge_b = (e.mag >= int'(thresh));
    e.cyc = 0;
    return e;
  endfunction

  // kind 0: flat 100, 1: vertical step at col 4, 2: vertical ramp row*10
  task automatic fill(input int kind);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        img[r][c] = (kind == 0) ? 100 : (kind == 1) ? ((c < 4) ? 0 : 255) : r * 10;
  endtask

  task automatic reset_dut();
    reset = 1'b1; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete(); obs_q.delete();
  endtask

  // Drives npix pixels of img in raster order; leaves in_valid high.
  task automatic drive_frame(input bit push, input int npix);
    for (int k = 0; k < npix; k++) begin
      int r, c, g;
      bit acc;
      r = k / IMG_W; c = k % IMG_W;
      in_valid = 1'b1; in_pixel = PIX_W'(img[r][c]);
      acc = 1'b0; g = 0;
      while (!acc && g < 100) begin
        @(negedge clk); acc = in_ready;
        @(posedge clk); #1; g++;
      end
      if (k == 0) first_acc = cyc;
      last_acc = cyc;
      if (r == 2 && c == 2) acc22 = cyc;
      if (push && r >= 2 && c >= 2) exp_q.push_back(model(r, c));
    end
  endtask

  task automatic wait_outputs(input int n);
    int k;
    k = 0;
    while (obs_q.size() < n && k < 400) begin @(negedge clk); k++; end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b1; thresh = '0;
    repeat (2) @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
    n_tests++; if (gx !== '0) begin n_fail++; $display("FAIL rst_gx got %0d want 0", gx); end
    n_tests++; if (gy !== '0) begin n_fail++; $display("FAIL rst_gy got %0d want 0", gy); end
    n_tests++; if (mag !== '0) begin n_fail++; $display("FAIL rst_mag got %0d want 0", mag); end
    n_tests++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_last got %0b want 0", out_last); end
    n_tests++; if (edge_w !== 1'b0) begin n_fail++; $display("FAIL rst_edge got %0b want 0", edge_w); end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_flat();
    int idx;
    reset_dut(); fill(0);
    drive_frame(1'b1, IMG_W * IMG_H); in_valid = 1'b0;
    wait_outputs(NOUT);
    n_tests++; if (obs_q.size() != NOUT) begin n_fail++; $display("FAIL flat_count got %0d want %0d", obs_q.size(), NOUT); end
    idx = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      res_t o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front(); idx++;
      n_tests++;
      if (o.gx != 0 || o.gy != 0 || o.mag != 0 || o.last != (idx == NOUT) || o.gx != e.gx || o.last != e.last) begin
        n_fail++; $display("FAIL flat_out[%0d] got gx=%0d gy=%0d mag=%0d last=%0b want 0 0 0 last=%0b", idx, o.gx, o.gy, o.mag, o.last, idx == NOUT);
      end
    end
  endtask

  task automatic test_step();
    int n255;
    reset_dut(); fill(1);
    drive_frame(1'b1, IMG_W * IMG_H); in_valid = 1'b0;
    wait_outputs(NOUT);
    n_tests++; if (obs_q.size() != NOUT) begin n_fail++; $display("FAIL step_count got %0d want %0d", obs_q.size(), NOUT); end
    n255 = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      res_t o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o.mag == 255 && o.gx == 1020) n255++;
      n_tests++;
      if (o.gx != e.gx || o.gy != e.gy || o.mag != e.mag || o.last != e.last) begin
        n_fail++; $display("FAIL step_out got %0d/%0d/%0d/%0b want %0d/%0d/%0d/%0b", o.gx, o.gy, o.mag, o.last, e.gx, e.gy, e.mag, e.last);
      end
    end
    n_tests++; if (n255 != 8) begin n_fail++; $display("FAIL step_saturated_windows got %0d want 8", n255); end
  endtask

  task automatic test_ramp_latency();
    reset_dut(); fill(2);
    drive_frame(1'b1, IMG_W * IMG_H); in_valid = 1'b0;
    wait_outputs(NOUT);
    n_tests++; if (obs_q.size() != NOUT) begin n_fail++; $display("FAIL ramp_count got %0d want %0d", obs_q.size(), NOUT); end
    if (obs_q.size() > 0) begin
      n_tests++;
      if (obs_q[0].cyc - acc22 != 2) begin n_fail++; $display("FAIL ramp_latency got %0d want 2", obs_q[0].cyc - acc22); end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      res_t o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_tests++;
      if (o.gx != 0 || o.gy != 80 || o.mag != 80 || o.last != e.last) begin
        n_fail++; $display("FAIL ramp_out got %0d/%0d/%0d/%0b want 0/80/80/%0b", o.gx, o.gy, o.mag, o.last, e.last);
      end
    end
  endtask

  task automatic test_stall();
    reset_dut(); fill(2);
    fork
      begin drive_frame(1'b1, IMG_W * IMG_H); in_valid = 1'b0; end
      begin
        int k;
        logic signed [PIX_W+2:0] hgx, hgy;
        logic [OUT_W-1:0] hmag;
        logic hlast;
        k = 0;
        while (obs_q.size() < 5 && k < 400) begin @(negedge clk); k++; end
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!out_valid && k < 100);
        hgx = gx; hgy = gy; hmag = mag; hlast = out_last;
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got %0b want 0", in_ready); end
          n_tests++;
          if (out_valid !== 1'b1 || gx !== hgx || gy !== hgy || mag !== hmag || out_last !== hlast) begin
            n_fail++; $display("FAIL stall_hold got v=%0b %0d/%0d/%0d want v=1 %0d/%0d/%0d", out_valid, gx, gy, mag, hgx, hgy, hmag);
          end
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    wait_outputs(NOUT);
    n_tests++; if (obs_q.size() != NOUT) begin n_fail++; $display("FAIL stall_count got %0d want %0d", obs_q.size(), NOUT); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      res_t o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_tests++;
      if (o.gx != e.gx || o.gy != e.gy || o.mag != e.mag || o.last != e.last) begin
        n_fail++; $display("FAIL stall_out got %0d/%0d/%0d/%0b want %0d/%0d/%0d/%0b", o.gx, o.gy, o.mag, o.last, e.gx, e.gy, e.mag, e.last);
      end
    end
  endtask

  task automatic test_back_to_back();
    longint f1_last, f2_first;
    int nlast;
    reset_dut(); fill(2);
    drive_frame(1'b1, IMG_W * IMG_H);
    f1_last = last_acc;
    fill(1);
    drive_frame(1'b1, IMG_W * IMG_H); in_valid = 1'b0;
    f2_first = first_acc;
    n_tests++; if (f2_first - f1_last != 1) begin n_fail++; $display("FAIL b2b_bubble got %0d want 1", f2_first - f1_last); end
    wait_outputs(2 * NOUT);
    n_tests++; if (obs_q.size() != 2 * NOUT) begin n_fail++; $display("FAIL b2b_count got %0d want %0d", obs_q.size(), 2 * NOUT); end
    nlast = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      res_t o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      nlast += int'(o.last);
      n_tests++;
      if (o.gx != e.gx || o.gy != e.gy || o.mag != e.mag || o.last != e.last) begin
        n_fail++; $display("FAIL b2b_out got %0d/%0d/%0d/%0b want %0d/%0d/%0d/%0b", o.gx, o.gy, o.mag, o.last, e.gx, e.gy, e.mag, e.last);
      end
    end
    n_tests++; if (nlast != 2) begin n_fail++; $display("FAIL b2b_last_count got %0d want 2", nlast); end
  endtask

  task automatic test_reset_mid();
    reset_dut(); fill(2);
    drive_frame(1'b0, 20);
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %0b want 0", out_valid); end
    @(posedge clk); #1 reset = 1'b0;
    repeat (6) @(negedge clk);
    n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL midrst_aborted got %0d outputs want 0", obs_q.size()); end
    obs_q.delete();
    fill(0);
    drive_frame(1'b1, IMG_W * IMG_H); in_valid = 1'b0;
    wait_outputs(NOUT);
    n_tests++; if (obs_q.size() != NOUT) begin n_fail++; $display("FAIL midrst_count got %0d want %0d", obs_q.size(), NOUT); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      res_t o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_tests++;
      if (o.gx != 0 || o.gy != 0 || o.mag != 0 || o.last != e.last) begin
        n_fail++; $display("FAIL midrst_out got %0d/%0d/%0d/%0b want 0/0/0/%0b", o.gx, o.gy, o.mag, o.last, e.last);
      end
    end
  endtask

`ifdef SOBEL_THRESH_EN
  task automatic test_thresh();
    for (int t = 0; t < 2; t++) begin
      int want;
      reset_dut(); fill(2);
      thresh = (t == 0) ? OUT_W'(50) : OUT_W'(81);
      want = (t == 0) ? 1 : 0;
      drive_frame(1'b1, IMG_W * IMG_H); in_valid = 1'b0;
      wait_outputs(NOUT);
      n_tests++; if (obs_q.size() != NOUT) begin n_fail++; $display("FAIL thresh_count got %0d want %0d", obs_q.size(), NOUT); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
        res_t o, e;
        o = obs_q.pop_front(); e = exp_q.pop_front();
        n_tests++;
        if (int'(o.edge_b) != want || o.mag != e.mag) begin
          n_fail++; $display("FAIL thresh_edge thr=%0d got edge=%0b mag=%0d want edge=%0d mag=%0d", thresh, o.edge_b, o.mag, want, e.mag);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_flat();
    test_step();
    test_ramp_latency();
    test_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef SOBEL_THRESH_EN
    test_thresh();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
